// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto a single-outstanding memory port
// Fetch and data requesters share one memory port; illegal addresses are answered locally.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_req_addr,
  output logic        i_rsp_valid,
  output logic        i_rsp_err,
  output logic [31:0] i_rsp_data,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  input  logic [3:0]  d_req_strb,
  output logic        d_rsp_valid,
  output logic        d_rsp_err,
  output logic [31:0] d_rsp_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_strb,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, ERR} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        owner_q, owner_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [3:0]  m_strb_q, m_strb_d;
  logic        i_rsp_valid_q, i_rsp_valid_d;
  logic        i_rsp_err_q, i_rsp_err_d;
  logic [31:0] i_rsp_data_q, i_rsp_data_d;
  logic        d_rsp_valid_q, d_rsp_valid_d;
  logic        d_rsp_err_q, d_rsp_err_d;
  logic [31:0] d_rsp_data_q, d_rsp_data_d;

  logic fetch_win;
  logic fetch_legal;
  logic data_region;
  logic data_aligned;
  logic data_legal;
  logic complete;

  always_comb begin
    fetch_legal = (i_req_addr < 32'h0000_1000) && (i_req_addr[1:0] == 2'b00);
    data_region = ((d_req_addr >= 32'h0000_1000) && (d_req_addr < 32'h0000_2000)) ||
                  (d_req_addr >= 32'h0040_0000);
    case (d_req_strb)
      4'b0000, 4'b1111:                   data_aligned = (d_req_addr[1:0] == 2'b00);
      4'b0011, 4'b1100:                   data_aligned = ~d_req_addr[0];
      4'b0001, 4'b0010, 4'b0100, 4'b1000: data_aligned = 1'b1;
      default:                            data_aligned = 1'b0;
    endcase
    data_legal = data_region && data_aligned;
  end

  // Data has priority unless fetch has been passed over STARVE_MAX times in a row.
  assign fetch_win   = i_req_valid && (!d_req_valid || (starve_q == STARVE_LIM));
  assign i_req_ready = !reset && (state_q == IDLE) && fetch_win;
  assign d_req_ready = !reset && (state_q == IDLE) && d_req_valid && !fetch_win;

  always_comb begin
    state_d       = state_q;
    starve_d      = starve_q;
    owner_d       = owner_q;
    m_addr_d      = m_addr_q;
    m_wdata_d     = m_wdata_q;
    m_strb_d      = m_strb_q;
    i_rsp_valid_d = 1'b0;
    i_rsp_err_d   = i_rsp_err_q;
    i_rsp_data_d  = i_rsp_data_q;
    d_rsp_valid_d = 1'b0;
    d_rsp_err_d   = d_rsp_err_q;
    d_rsp_data_d  = d_rsp_data_q;
    complete      = 1'b0;

    if (i_req_ready || !i_req_valid) begin
      starve_d = 4'd0;
    end else if (d_req_ready && (starve_q != 4'hF)) begin
      starve_d = starve_q + 4'd1;
    end

    case (state_q)
      IDLE: begin
        if (i_req_ready) begin
          owner_d = 1'b0;
          if (fetch_legal) begin
            state_d   = REQ;
            m_addr_d  = i_req_addr;
            m_wdata_d = 32'h0;
            m_strb_d  = 4'h0;
          end else begin
            state_d      = ERR;
            i_rsp_valid_d = 1'b1;
            i_rsp_err_d   = 1'b1;
            i_rsp_data_d  = 32'h0;
          end
        end else if (d_req_ready) begin
          owner_d = 1'b1;
          if (data_legal) begin
            state_d   = REQ;
            m_addr_d  = d_req_addr;
            m_wdata_d = d_req_wdata;
            m_strb_d  = d_req_strb;
          end else begin
            state_d      = ERR;
            d_rsp_valid_d = 1'b1;
            d_rsp_err_d   = 1'b1;
            d_rsp_data_d  = 32'h0;
          end
        end
      end
      REQ: begin
        if (m_ready) begin
          if (m_rvalid) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (m_rvalid) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (complete) begin
      if (owner_q) begin
        d_rsp_valid_d = 1'b1;
        d_rsp_err_d   = 1'b0;
        d_rsp_data_d  = m_rdata;
      end else begin
        i_rsp_valid_d = 1'b1;
        i_rsp_err_d   = 1'b0;
        i_rsp_data_d  = m_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      starve_q      <= 4'd0;
      owner_q       <= 1'b0;
      m_addr_q      <= 32'h0;
      m_wdata_q     <= 32'h0;
      m_strb_q      <= 4'h0;
      i_rsp_valid_q <= 1'b0;
      i_rsp_err_q   <= 1'b0;
      i_rsp_data_q  <= 32'h0;
      d_rsp_valid_q <= 1'b0;
      d_rsp_err_q   <= 1'b0;
      d_rsp_data_q  <= 32'h0;
    end else begin
      state_q       <= state_d;
      starve_q      <= starve_d;
      owner_q       <= owner_d;
      m_addr_q      <= m_addr_d;
      m_wdata_q     <= m_wdata_d;
      m_strb_q      <= m_strb_d;
      i_rsp_valid_q <= i_rsp_valid_d;
      i_rsp_err_q   <= i_rsp_err_d;
      i_rsp_data_q  <= i_rsp_data_d;
      d_rsp_valid_q <= d_rsp_valid_d;
      d_rsp_err_q   <= d_rsp_err_d;
      d_rsp_data_q  <= d_rsp_data_d;
    end
  end

  assign m_valid     = (state_q == REQ);
  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign m_strb      = m_strb_q;
  assign i_rsp_valid = i_rsp_valid_q;
  assign i_rsp_err   = i_rsp_err_q;
  assign i_rsp_data  = i_rsp_data_q;
  assign d_rsp_valid = d_rsp_valid_q;
  assign d_rsp_err   = d_rsp_err_q;
  assign d_rsp_data  = d_rsp_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_err;
  logic [31:0] i_req_addr, i_rsp_data;
  logic        d_req_valid, d_req_ready, d_rsp_valid, d_rsp_err;
  logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
  logic [3:0]  d_req_strb;
  logic        m_valid, m_ready, m_rvalid;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_strb;

  logic        mem_auto, mem_rand;
  logic        auto_ready, auto_rvalid, man_ready, man_rvalid;
  logic [31:0] auto_rdata, man_rdata;

  rsp_t exp_i_q[$], exp_d_q[$], rx_i_q[$], rx_d_q[$];
  bit   grant_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   fire_cnt = 0;
  int   both_cnt = 0;
  int   d_rsp_cyc = 0;
  int   f_grant_cyc = 0;

  assign m_ready  = mem_auto ? auto_ready  : man_ready;
  assign m_rvalid = mem_auto ? auto_rvalid : man_rvalid;
  assign m_rdata  = mem_auto ? auto_rdata  : man_rdata;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_err(i_rsp_err), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_strb(d_req_strb),
    .d_rsp_valid(d_rsp_valid), .d_rsp_err(d_rsp_err), .d_rsp_data(d_rsp_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_strb(m_strb), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic bit f_legal(input logic [31:0] a);
    return (a < 32'h1000) && (a % 4 == 0);
  endfunction

  function automatic bit d_legal(input logic [31:0] a, input logic [3:0] s);
    bit region;
    bit al;
    region = (a >= 32'h1000 && a < 32'h2000) || (a >= 32'h0040_0000);
    if (s == 4'b0000 || s == 4'b1111) al = (a % 4 == 0);
    else if (s == 4'b0011 || s == 4'b1100) al = (a % 2 == 0);
    else al = 1'b0;
    return region && al;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (i_rsp_valid) rx_i_q.push_back(rsp_t'({i_rsp_err, i_rsp_data}));
    if (d_rsp_valid) begin
      rx_d_q.push_back(rsp_t'({d_rsp_err, d_rsp_data}));
      d_rsp_cyc <= cyc;
    end
    if (i_rsp_valid && d_rsp_valid) both_cnt <= both_cnt + 1;
    if (i_req_valid && i_req_ready) begin
      grant_q.push_back(1'b0);
      f_grant_cyc <= cyc;
    end
    if (d_req_valid && d_req_ready) grant_q.push_back(1'b1);
    if (m_valid && m_ready) fire_cnt <= fire_cnt + 1;
  end

  initial begin : mem_model
    logic        fire;
    logic [31:0] faddr;
    auto_ready = 1'b1; auto_rvalid = 1'b0; auto_rdata = 32'h0;
    forever begin
      @(negedge clk);
      fire  = mem_auto && m_valid && m_ready;
      faddr = m_addr;
      @(posedge clk); #1;
      auto_rvalid = fire;
      auto_rdata  = fire ? mem_rd(faddr) : 32'h0;
      auto_ready  = mem_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drv_fetch(input logic [31:0] addr, output bit ok);
    rsp_t e;
    int   n;
    e.err  = !f_legal(addr);
    e.data = e.err ? 32'h0 : mem_rd(addr);
    exp_i_q.push_back(e);
    i_req_addr = addr; i_req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!i_req_ready && n < 300) begin @(negedge clk); n++; end
    ok = i_req_ready;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
  endtask

  task automatic drv_data(input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] wdata, output bit ok);
    rsp_t e;
    int   n;
    e.err  = !d_legal(addr, strb);
    e.data = e.err ? 32'h0 : mem_rd(addr);
    exp_d_q.push_back(e);
    d_req_addr = addr; d_req_strb = strb; d_req_wdata = wdata; d_req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!d_req_ready && n < 300) begin @(negedge clk); n++; end
    ok = d_req_ready;
    @(posedge clk); #1;
    d_req_valid = 1'b0;
  endtask

  task automatic wait_rx(output bit ok);
    int n = 0;
    while ((rx_i_q.size() < exp_i_q.size() || rx_d_q.size() < exp_d_q.size()) && n < 400) begin
      @(posedge clk); n++;
    end
    @(posedge clk); #1;
    ok = (rx_i_q.size() == exp_i_q.size()) && (rx_d_q.size() == exp_d_q.size());
  endtask

  task automatic clear_sb();
    exp_i_q.delete(); exp_d_q.delete(); rx_i_q.delete(); rx_d_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_auto = 1'b0; mem_rand = 1'b0;
    man_ready = 1'b1; man_rvalid = 1'b1; man_rdata = 32'hFFFF_FFFF;
    i_req_valid = 1'b1; i_req_addr = 32'h0;
    d_req_valid = 1'b1; d_req_addr = 32'h1000; d_req_wdata = 32'h0; d_req_strb = 4'h0;
    @(negedge clk);
    n_checks++;
    if ({i_req_ready, d_req_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 00", {i_req_ready, d_req_ready});
    end
    n_checks++;
    if ({i_rsp_valid, i_rsp_err, i_rsp_data, d_rsp_valid, d_rsp_err, d_rsp_data,
         m_valid, m_addr, m_wdata, m_strb} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got rsp %b%b%h %b%b%h m %b %h %h %h expected all zero",
        i_rsp_valid, i_rsp_err, i_rsp_data, d_rsp_valid, d_rsp_err, d_rsp_data,
        m_valid, m_addr, m_wdata, m_strb);
    end
    @(posedge clk); #1;
    i_req_valid = 1'b0; d_req_valid = 1'b0; man_ready = 1'b0; man_rvalid = 1'b0; reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({m_valid, i_rsp_valid, d_rsp_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_release_idle: got %b expected 000", {m_valid, i_rsp_valid, d_rsp_valid});
    end
    @(posedge clk); #1;
    clear_sb();
  endtask

  task automatic test_fetch_latency();
    i_req_valid = 1'b1; i_req_addr = 32'h0000_0400;
    @(negedge clk);
    n_checks++;
    if ({i_req_ready, d_req_ready} !== 2'b10) begin
      n_fail++; $display("FAIL fetch_accept: got %b expected 10", {i_req_ready, d_req_ready});
    end
    @(posedge clk); #1;
    i_req_valid = 1'b0; man_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({m_valid, m_addr, m_strb} !== {1'b1, 32'h0000_0400, 4'h0}) begin
      n_fail++; $display("FAIL fetch_mreq: got %b %h %h expected 1 00000400 0", m_valid, m_addr, m_strb);
    end
    @(posedge clk); #1;
    man_ready = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h0000_0013;
    @(negedge clk);
    n_checks++;
    if (i_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL fetch_early_rsp: got %b expected 0", i_rsp_valid);
    end
    @(posedge clk); #1;
    man_rvalid = 1'b0; man_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    n_checks++;
    if ({i_rsp_valid, i_rsp_err, i_rsp_data, d_rsp_valid} !== {1'b1, 1'b0, 32'h0000_0013, 1'b0}) begin
      n_fail++; $display("FAIL fetch_rsp: got %b %b %h %b expected 1 0 00000013 0",
        i_rsp_valid, i_rsp_err, i_rsp_data, d_rsp_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({i_rsp_valid, i_rsp_data} !== {1'b0, 32'h0000_0013}) begin
      n_fail++; $display("FAIL fetch_rsp_hold: got %b %h expected 0 00000013", i_rsp_valid, i_rsp_data);
    end
    @(posedge clk); #1;
    clear_sb();
  endtask

  task automatic test_direct_complete();
    d_req_valid = 1'b1; d_req_addr = 32'h0000_1004; d_req_strb = 4'h0;
    @(negedge clk);
    n_checks++;
    if (d_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL direct_accept: got %b expected 1", d_req_ready);
    end
    @(posedge clk); #1;
    d_req_valid = 1'b0; man_ready = 1'b1; man_rvalid = 1'b1; man_rdata = 32'h0000_55AA;
    @(posedge clk); #1;
    man_ready = 1'b0; man_rvalid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({d_rsp_valid, d_rsp_err, d_rsp_data} !== {1'b1, 1'b0, 32'h0000_55AA}) begin
      n_fail++; $display("FAIL direct_rsp: got %b %b %h expected 1 0 000055aa", d_rsp_valid, d_rsp_err, d_rsp_data);
    end
    @(posedge clk); #1;
    man_rvalid = 1'b1; man_rdata = 32'h0000_0999;
    @(posedge clk); #1;
    man_rvalid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({i_rsp_valid, d_rsp_valid, d_rsp_data} !== {1'b0, 1'b0, 32'h0000_55AA}) begin
      n_fail++; $display("FAIL stray_rvalid: got %b %b %h expected 0 0 000055aa", i_rsp_valid, d_rsp_valid, d_rsp_data);
    end
    @(posedge clk); #1;
    clear_sb();
  endtask

  task automatic test_priority();
    bit   okf, okd, ok;
    rsp_t e, r;
    mem_auto = 1'b1;
    fork
      drv_data(32'h0000_1000, 4'h0, 32'h0, okd);
      drv_fetch(32'h0000_0404, okf);
      begin
        @(negedge clk);
        n_checks++;
        if ({d_req_ready, i_req_ready} !== 2'b10) begin
          n_fail++; $display("FAIL priority_grant: got d=%b i=%b expected d=1 i=0", d_req_ready, i_req_ready);
        end
      end
    join
    wait_rx(ok);
    n_checks++;
    if (!(okf && okd && ok)) begin
      n_fail++; $display("FAIL priority_progress: got accept %b%b drained %b expected 111", okf, okd, ok);
    end
    n_checks++;
    if (f_grant_cyc < d_rsp_cyc) begin
      n_fail++; $display("FAIL priority_order: fetch grant cycle %0d, required >= data rsp cycle %0d", f_grant_cyc, d_rsp_cyc);
    end
    while (exp_i_q.size() > 0 && rx_i_q.size() > 0) begin
      e = exp_i_q.pop_front(); r = rx_i_q.pop_front(); n_checks++;
      if (r !== e) begin n_fail++; $display("FAIL priority_i_rsp: got %b/%h expected %b/%h", r.err, r.data, e.err, e.data); end
    end
    while (exp_d_q.size() > 0 && rx_d_q.size() > 0) begin
      e = exp_d_q.pop_front(); r = rx_d_q.pop_front(); n_checks++;
      if (r !== e) begin n_fail++; $display("FAIL priority_d_rsp: got %b/%h expected %b/%h", r.err, r.data, e.err, e.data); end
    end
    clear_sb();
  endtask

  task automatic test_starvation();
    bit   okf, okd, ok, exp_g;
    rsp_t e, r;
    okf = 1'b1; okd = 1'b1;
    grant_q.delete();
    fork
      for (int k = 0; k < 3; k++) begin
        bit o;
        drv_fetch(32'h0000_0100 + 32'(k * 4), o);
        okf &= o;
      end
      for (int k = 0; k < 12; k++) begin
        bit o;
        drv_data(32'h0000_1100 + 32'(k * 4), (k % 2 == 0) ? 4'hF : 4'h0, 32'hA000_0000 + 32'(k), o);
        okd &= o;
      end
    join
    wait_rx(ok);
    n_checks++;
    if (!(okf && okd && ok && grant_q.size() == 15)) begin
      n_fail++; $display("FAIL starve_progress: got accept %b%b drained %b grants %0d expected 111 and 15",
        okf, okd, ok, grant_q.size());
    end
    for (int k = 0; k < 15 && k < grant_q.size(); k++) begin
      exp_g = (k % 5 != 4);
      n_checks++;
      if (grant_q[k] !== exp_g) begin
        n_fail++; $display("FAIL starve_grant_%0d: got %s expected %s", k, grant_q[k] ? "data" : "fetch", exp_g ? "data" : "fetch");
      end
    end
    while (exp_i_q.size() > 0 && rx_i_q.size() > 0) begin
      e = exp_i_q.pop_front(); r = rx_i_q.pop_front(); n_checks++;
      if (r !== e) begin n_fail++; $display("FAIL starve_i_rsp: got %b/%h expected %b/%h", r.err, r.data, e.err, e.data); end
    end
    while (exp_d_q.size() > 0 && rx_d_q.size() > 0) begin
      e = exp_d_q.pop_front(); r = rx_d_q.pop_front(); n_checks++;
      if (r !== e) begin n_fail++; $display("FAIL starve_d_rsp: got %b/%h expected %b/%h", r.err, r.data, e.err, e.data); end
    end
    clear_sb();
  endtask

  task automatic test_illegal();
    logic [31:0] d_addr [8] = '{32'h1FFC, 32'h2000, 32'h003F_FFFC, 32'h0040_0000,
                                32'h1002, 32'h1001, 32'h1002, 32'h0FFC};
    logic [3:0]  d_strb [8] = '{4'hF, 4'hF, 4'h0, 4'hF, 4'hC, 4'h3, 4'hF, 4'h0};
    logic [31:0] f_addr [4] = '{32'h0402, 32'h0FFC, 32'h1000, 32'h0000};
    int   n_legal, fire0;
    bit   o, ok_all, ok;
    rsp_t e, r;
    d_req_valid = 1'b1; d_req_addr = 32'h0000_0800; d_req_strb = 4'hF; d_req_wdata = 32'h1234_5678;
    @(negedge clk);
    n_checks++;
    if (d_req_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_accept: got %b expected 1", d_req_ready); end
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({m_valid, d_rsp_valid, d_rsp_err, d_rsp_data} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL illegal_rsp: got m_valid %b rsp %b err %b data %h expected 0 1 1 00000000",
        m_valid, d_rsp_valid, d_rsp_err, d_rsp_data);
    end
    @(posedge clk); #1;
    clear_sb();
    mem_rand = 1'b1;
    fire0 = fire_cnt; n_legal = 0; ok_all = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drv_data(d_addr[k], d_strb[k], 32'hC0DE_0000 + 32'(k), o);
      ok_all &= o;
      n_legal += d_legal(d_addr[k], d_strb[k]) ? 1 : 0;
    end
    for (int k = 0; k < 4; k++) begin
      drv_fetch(f_addr[k], o);
      ok_all &= o;
      n_legal += f_legal(f_addr[k]) ? 1 : 0;
    end
    wait_rx(ok);
    n_checks++;
    if (!(ok_all && ok)) begin n_fail++; $display("FAIL addr_progress: got accept %b drained %b expected 11", ok_all, ok); end
    n_checks++;
    if (fire_cnt - fire0 != n_legal) begin
      n_fail++; $display("FAIL addr_mem_issue: got %0d memory requests expected %0d", fire_cnt - fire0, n_legal);
    end
    while (exp_i_q.size() > 0 && rx_i_q.size() > 0) begin
      e = exp_i_q.pop_front(); r = rx_i_q.pop_front(); n_checks++;
      if (r !== e) begin n_fail++; $display("FAIL addr_i_rsp: got %b/%h expected %b/%h", r.err, r.data, e.err, e.data); end
    end
    while (exp_d_q.size() > 0 && rx_d_q.size() > 0) begin
      e = exp_d_q.pop_front(); r = rx_d_q.pop_front(); n_checks++;
      if (r !== e) begin n_fail++; $display("FAIL addr_d_rsp: got %b/%h expected %b/%h", r.err, r.data, e.err, e.data); end
    end
    mem_rand = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_sb();
  endtask

  task automatic test_stall_and_reset();
    bit   seen, o, ok;
    rsp_t e, r;
    mem_auto = 1'b0; man_ready = 1'b0; man_rvalid = 1'b0;
    d_req_valid = 1'b1; d_req_addr = 32'h0000_1010; d_req_wdata = 32'hDEAD_BEEF; d_req_strb = 4'hF;
    @(negedge clk);
    n_checks++;
    if (d_req_ready !== 1'b1) begin n_fail++; $display("FAIL stall_accept: got %b expected 1", d_req_ready); end
    @(posedge clk); #1;
    d_req_valid = 1'b0; d_req_addr = 32'h0; d_req_wdata = 32'h0; d_req_strb = 4'h0;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) man_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({m_valid, m_addr, m_wdata, m_strb} !== {1'b1, 32'h0000_1010, 32'hDEAD_BEEF, 4'hF}) begin
        n_fail++; $display("FAIL stall_hold_%0d: got %b %h %h %h expected 1 00001010 deadbeef f",
          k, m_valid, m_addr, m_wdata, m_strb);
      end
      @(posedge clk); #1;
    end
    man_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({m_valid, d_rsp_valid} !== 2'b00) begin
      n_fail++; $display("FAIL wait_state: got m_valid %b rsp %b expected 0 0", m_valid, d_rsp_valid);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({m_valid, m_addr, m_wdata, m_strb, d_rsp_valid, d_rsp_err, d_rsp_data, i_rsp_data} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got %b %h %h %h %b %b %h %h expected all zero",
        m_valid, m_addr, m_wdata, m_strb, d_rsp_valid, d_rsp_err, d_rsp_data, i_rsp_data);
    end
    @(posedge clk); #1;
    reset = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h0000_0BAD;
    @(posedge clk); #1;
    man_rvalid = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen |= (i_rsp_valid === 1'b1) || (d_rsp_valid === 1'b1);
    end
    @(posedge clk); #1;
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL stale_rvalid: got a response pulse expected none"); end
    clear_sb();
    mem_auto = 1'b1;
    drv_fetch(32'h0000_0008, o);
    wait_rx(ok);
    n_checks++;
    if (!(o && ok)) begin n_fail++; $display("FAIL post_reset_progress: got accept %b drained %b expected 11", o, ok); end
    while (exp_i_q.size() > 0 && rx_i_q.size() > 0) begin
      e = exp_i_q.pop_front(); r = rx_i_q.pop_front(); n_checks++;
      if (r !== e) begin n_fail++; $display("FAIL post_reset_rsp: got %b/%h expected %b/%h", r.err, r.data, e.err, e.data); end
    end
    clear_sb();
  endtask

  task automatic test_exclusive_rsp();
    n_checks++;
    if (both_cnt != 0) begin
      n_fail++; $display("FAIL rsp_exclusive: got %0d cycles with both rsp_valid expected 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_latency();
    test_direct_complete();
    test_priority();
    test_starvation();
    test_illegal();
    test_stall_and_reset();
    test_exclusive_rsp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
